// File: rtl/valu_pkg.sv
// valu_pkg: shared constants and helpers for the vector ALU issue front end.
//   - Opcode / func / PPP / WW encodings
//   - Instruction field positions (big-endian numbering, instr[0:31])
//   - Issue FSM state enum
//   - Legality check and PPP byte-merge helpers
package valu_pkg;

    localparam logic [5:0] OPC_VALU = 6'b101010;

    // func field encodings (legal range VAND..VSQRT)
    localparam logic [5:0] VAND   = 6'b000001;
    localparam logic [5:0] VOR    = 6'b000010;
    localparam logic [5:0] VXOR   = 6'b000011;
    localparam logic [5:0] VNOT   = 6'b000100;
    localparam logic [5:0] VMOV   = 6'b000101;
    localparam logic [5:0] VADD   = 6'b000110;
    localparam logic [5:0] VSUB   = 6'b000111;
    localparam logic [5:0] VMULEU = 6'b001000;
    localparam logic [5:0] VMULOU = 6'b001001;
    localparam logic [5:0] VSLL   = 6'b001010;
    localparam logic [5:0] VSRL   = 6'b001011;
    localparam logic [5:0] VSRA   = 6'b001100;
    localparam logic [5:0] VRTTH  = 6'b001101;
    localparam logic [5:0] VDIV   = 6'b001110;
    localparam logic [5:0] VMOD   = 6'b001111;
    localparam logic [5:0] VSQEU  = 6'b010000;
    localparam logic [5:0] VSQOU  = 6'b010001;
    localparam logic [5:0] VSQRT  = 6'b010010;

    // PPP byte-participation codes (byte 0 = bits [0:7], the MSB byte)
    localparam logic [2:0] PPP_ALL   = 3'b000;
    localparam logic [2:0] PPP_UPPER = 3'b001;  // bytes 0-3
    localparam logic [2:0] PPP_LOWER = 3'b010;  // bytes 4-7
    localparam logic [2:0] PPP_EVEN  = 3'b011;  // bytes 0,2,4,6
    localparam logic [2:0] PPP_ODD   = 3'b100;  // bytes 1,3,5,7

    // WW element width codes
    localparam logic [1:0] WW_B = 2'b00;
    localparam logic [1:0] WW_H = 2'b01;
    localparam logic [1:0] WW_W = 2'b10;
    localparam logic [1:0] WW_D = 2'b11;

    // Field start positions within instr[0:31]; use as instr[F_x +: width]
    localparam int F_OPC  = 0;
    localparam int F_RD   = 6;
    localparam int F_RA   = 11;
    localparam int F_RB   = 16;
    localparam int F_PPP  = 21;
    localparam int F_WW   = 24;
    localparam int F_FUNC = 26;

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic is_legal(input logic [0:31] ins);
        logic [5:0] opc;
        logic [5:0] fn;
        logic [2:0] ppp;
        opc = ins[F_OPC +: 6];
        fn  = ins[F_FUNC +: 6];
        ppp = ins[F_PPP +: 3];
        return (opc == OPC_VALU) && (fn >= VAND) && (fn <= VSQRT) && (ppp <= PPP_ODD);
    endfunction

    function automatic logic [0:7] ppp_byte_en(input logic [2:0] ppp);
        logic [0:7] en;
        case (ppp)
            PPP_ALL:   en = 8'b1111_1111;
            PPP_UPPER: en = 8'b1111_0000;
            PPP_LOWER: en = 8'b0000_1111;
            PPP_EVEN:  en = 8'b1010_1010;
            PPP_ODD:   en = 8'b0101_0101;
            default:   en = 8'b0000_0000;
        endcase
        return en;
    endfunction

    function automatic logic [0:63] ppp_merge(input logic [0:63] nv,
                                              input logic [0:63] ov,
                                              input logic [2:0]  ppp);
        logic [0:7]  en;
        logic [0:63] r;
        en = ppp_byte_en(ppp);
        for (int i = 0; i < 8; i++)
            r[8*i +: 8] = en[i] ? nv[8*i +: 8] : ov[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/valu_regfile.sv
// valu_regfile: NREG x 64-bit register file, cleared asynchronously on rst.
//   clk, rst            clock, async active-high clear
//   we/waddr/wdata      single write port (arbitrated by the issue FSM)
//   raddr_a/rdata_a     operand / merge read port (combinational)
//   raddr_b/rdata_b     operand read port (combinational)
//   raddr_d/rdata_d     debug read port (combinational)
module valu_regfile #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [0:4]  waddr,
    input  logic [0:63] wdata,
    input  logic [0:4]  raddr_a,
    output logic [0:63] rdata_a,
    input  logic [0:4]  raddr_b,
    output logic [0:63] rdata_b,
    input  logic [0:4]  raddr_d,
    output logic [0:63] rdata_d
);

    logic [0:63] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-write contents on the edge of a write.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_d = mem[raddr_d];

endmodule

// File: rtl/valu_issue.sv
// valu_issue: instruction front end for the combinational vector ALU.
//   Accepts R-type instruction words (instr_valid/instr_ready), checks legality,
//   reads operands from the internal register file, drives registered ALU
//   controls, waits ALU_LAT cycles and writes alu_out back to rD merged under
//   the PPP byte mask.
// Ports:
//   clk, rst                     clock, async active-high reset
//   instr_valid/instr/instr_ready  instruction handshake (ready only in IDLE)
//   alu_rA/alu_rB/alu_R_ins/alu_Op_code/alu_WW  registered ALU inputs
//   alu_out                      combinational ALU result
//   wb_valid/wb_addr/wb_data     one-cycle report of each register write-back
//   illegal                      one-cycle pulse per dropped illegal instruction
//   rf_we/rf_waddr/rf_wdata      preload write port (honoured in IDLE only)
//   rf_raddr/rf_rdata            combinational debug read
//   retired_cnt/illegal_cnt      perf counters, present when VALU_PERF_CNT_EN
//                                is defined, otherwise tied to 0
// ALU_LAT must be in 1..15 (4-bit settle counter).
module valu_issue
    import valu_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int NREG    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [0:31] instr,
    output logic        instr_ready,
    output logic [0:63] alu_rA,
    output logic [0:63] alu_rB,
    output logic [0:5]  alu_R_ins,
    output logic [0:5]  alu_Op_code,
    output logic [0:1]  alu_WW,
    input  logic [0:63] alu_out,
    output logic        wb_valid,
    output logic [0:4]  wb_addr,
    output logic [0:63] wb_data,
    output logic        illegal,
    input  logic        rf_we,
    input  logic [0:4]  rf_waddr,
    input  logic [0:63] rf_wdata,
    input  logic [0:4]  rf_raddr,
    output logic [0:63] rf_rdata,
    output logic [0:31] retired_cnt,
    output logic [0:31] illegal_cnt
);

    state_t      state;
    logic [3:0]  cnt;
    logic [0:4]  rd_q;
    logic [2:0]  ppp_q;

    logic        accept, legal, wb_fire, ill_fire;
    logic        we;
    logic [0:4]  waddr;
    logic [0:63] wdata;
    logic [0:4]  raddr_a;
    logic [0:63] rdata_a, rdata_b;
    logic [0:63] merged;

    assign accept   = instr_valid && instr_ready;
    assign legal    = is_legal(instr);
    assign wb_fire  = (state == WAIT) && (cnt == 4'(ALU_LAT));
    assign ill_fire = accept && !legal;

    // Port A doubles as the merge read: in IDLE it fetches rA, in WAIT the
    // operands are already latched so it fetches the old rD contents.
    assign raddr_a = (state == WAIT) ? rd_q : instr[F_RA +: 5];
    assign merged  = ppp_merge(alu_out, rdata_a, ppp_q);

    // Single write port: preload owns it in IDLE, write-back in WAIT.
    always_comb begin
        we    = 1'b0;
        waddr = rf_waddr;
        wdata = rf_wdata;
        if (state == IDLE) begin
            we = rf_we;
        end else if (wb_fire) begin
            we    = 1'b1;
            waddr = rd_q;
            wdata = merged;
        end
    end

    valu_regfile #(.NREG(NREG)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (instr[F_RB +: 5]),
        .rdata_b (rdata_b),
        .raddr_d (rf_raddr),
        .rdata_d (rf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            cnt         <= '0;
            rd_q        <= '0;
            ppp_q       <= '0;
            alu_rA      <= '0;
            alu_rB      <= '0;
            alu_R_ins   <= '0;
            alu_Op_code <= '0;
            alu_WW      <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            illegal     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            alu_rA      <= rdata_a;
                            alu_rB      <= rdata_b;
                            alu_R_ins   <= instr[F_FUNC +: 6];
                            alu_Op_code <= instr[F_OPC +: 6];
                            alu_WW      <= instr[F_WW +: 2];
                            rd_q        <= instr[F_RD +: 5];
                            ppp_q       <= instr[F_PPP +: 3];
                            cnt         <= 4'd1;
                            state       <= WAIT;
                            instr_ready <= 1'b0;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (wb_fire) begin
                        wb_valid    <= 1'b1;
                        wb_addr     <= rd_q;
                        wb_data     <= merged;
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef VALU_PERF_CNT_EN
    logic [0:31] ret_q, ill_q;

    // Counted on the same edge that raises the matching pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_q <= '0;
            ill_q <= '0;
        end else begin
            if (wb_fire)  ret_q <= ret_q + 32'd1;
            if (ill_fire) ill_q <= ill_q + 32'd1;
        end
    end

    assign retired_cnt = ret_q;
    assign illegal_cnt = ill_q;
`else
    logic unused_ill;
    assign unused_ill  = ill_fire;
    assign retired_cnt = '0;
    assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_valu_issue.sv
module tb_valu_issue;

    localparam int ALU_LAT = 2;

    logic        clk = 0;
    logic        rst = 1;
    logic        instr_valid = 0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [63:0] alu_rA, alu_rB;
    logic [5:0]  alu_R_ins, alu_Op_code;
    logic [1:0]  alu_WW;
    logic [63:0] alu_out;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        illegal;
    logic        rf_we = 0;
    logic [4:0]  rf_waddr = '0;
    logic [63:0] rf_wdata = '0;
    logic [4:0]  rf_raddr = '0;
    logic [63:0] rf_rdata;
    logic [31:0] retired_cnt, illegal_cnt;

    int tests = 0, fails = 0;
    int cyc = 0;
    int n_ret = 0, n_ill = 0;
    int last_acc = 0;
    logic [63:0] model [32];

    valu_issue #(.ALU_LAT(ALU_LAT), .NREG(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_rA(alu_rA), .alu_rB(alu_rB),
        .alu_R_ins(alu_R_ins), .alu_Op_code(alu_Op_code), .alu_WW(alu_WW),
        .alu_out(alu_out), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .illegal(illegal), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: a few real ops plus a deterministic scramble for the rest.
    function automatic logic [63:0] talu(input logic [63:0] a, input logic [63:0] b,
                                         input logic [5:0] f);
        case (f)
            6'd1: return a & b;
            6'd2: return a | b;
            6'd3: return a ^ b;
            6'd4: return ~a;
            6'd5: return a;
            6'd6: return a + b;
            6'd7: return a - b;
            default: return (a ^ {b[31:0], b[63:32]}) + {58'd0, f};
        endcase
    endfunction

    assign alu_out = talu(alu_rA, alu_rB, alu_R_ins);

    // Byte i is the i-th most significant byte.
    function automatic logic [63:0] mmerge(input logic [63:0] nv, input logic [63:0] ov,
                                           input logic [2:0] ppp);
        logic [63:0] r;
        bit en;
        for (int i = 0; i < 8; i++) begin
            en = (ppp == 0) || (ppp == 1 && i < 4) || (ppp == 2 && i >= 4) ||
                 (ppp == 3 && i % 2 == 0) || (ppp == 4 && i % 2 == 1);
            r[63-8*i -: 8] = en ? nv[63-8*i -: 8] : ov[63-8*i -: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [2:0] ppp, input logic [1:0] ww,
                                       input logic [5:0] fn);
        return {op, rd, ra, rb, ppp, ww, fn};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rf_chk(input string tag, input logic [4:0] a, input logic [63:0] exp);
        rf_raddr = a;
        #1;
        chk(tag, rf_rdata, exp);
    endtask

    task automatic preload(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        rf_we = 1; rf_waddr = a; rf_wdata = d;
        @(posedge clk); #1;
        rf_we = 0;
        model[a] = d;
    endtask

    // Offer one instruction, optionally with a same-edge preload and with a
    // preload attempt held asserted throughout WAIT (which must be ignored).
    task automatic issue(input logic [31:0] ins, input bit pl, input logic [4:0] pa,
                         input logic [63:0] pd, input bit junk);
        logic [5:0] op, fn;
        logic [4:0] rd, ra, rb;
        logic [2:0] ppp;
        logic [1:0] ww;
        logic [63:0] opa, opb, res;
        logic [5:0] rins_before;
        bit lg;
        int n;
        op = ins[31:26]; rd = ins[25:21]; ra = ins[20:16]; rb = ins[15:11];
        ppp = ins[10:8]; ww = ins[7:6]; fn = ins[5:0];
        lg = (op == 6'b101010) && (fn >= 1) && (fn <= 18) && (ppp <= 4);
        rins_before = alu_R_ins;
        @(negedge clk);
        instr = ins; instr_valid = 1;
        if (pl) begin rf_we = 1; rf_waddr = pa; rf_wdata = pd; end
        @(posedge clk); #1;
        instr_valid = 0; rf_we = 0;
        opa = model[ra]; opb = model[rb];
        if (pl) model[pa] = pd;
        if (!lg) begin
            n_ill++;
            chk("illegal_pulse", illegal, 1);
            chk("illegal_ready", instr_ready, 1);
            chk("illegal_no_wb", wb_valid, 0);
            chk("illegal_alu_hold", alu_R_ins, rins_before);
            @(posedge clk); #1;
            chk("illegal_one_cycle", illegal, 0);
            return;
        end
        last_acc = cyc;
        chk("accept_ready_low", instr_ready, 0);
        chk("alu_rA", alu_rA, opa);
        chk("alu_rB", alu_rB, opb);
        chk("alu_R_ins", alu_R_ins, fn);
        chk("alu_Op_code", alu_Op_code, op);
        chk("alu_WW", alu_WW, ww);
        if (junk) begin rf_we = 1; rf_waddr = rd; rf_wdata = 64'hDEADBEEF_CAFEF00D; end
        n = 0;
        while (!wb_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!wb_valid) chk("wait_ready_low", instr_ready, 0);
        end
        rf_we = 0;
        res = mmerge(talu(opa, opb, fn), model[rd], ppp);
        model[rd] = res;
        n_ret++;
        chk("wb_latency", n, ALU_LAT);
        chk("wb_ready_high", instr_ready, 1);
        chk("wb_addr", wb_addr, rd);
        chk("wb_data", wb_data, res);
        rf_chk("rf_after_wb", rd, res);
    endtask

    initial begin
        int acc1;
        int seen;
        logic [31:0] ins;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_alu_rA", alu_rA, 0);
        chk("rst_alu_R_ins", alu_R_ins, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_retired", retired_cnt, 0);
        rf_chk("rst_rf5", 5, 0);
        @(negedge clk) rst = 0;

        // 1: VAND r3 = r1 & r2
        preload(1, 64'h0F);
        preload(2, 64'h0E);
        chk("mk_encoding", mk(6'b101010, 3, 1, 2, 0, 2'b10, 1), 32'hA8611081);
        issue(32'hA8611081, 0, 0, 0, 0);
        rf_chk("t1_r3", 3, 64'h0E);

        // 2: VADD r6 = r1 + r2, upper bytes only
        preload(6, 64'h11111111_22222222);
        issue(mk(6'b101010, 6, 1, 2, 3'b001, 2'b11, 6'd6), 0, 0, 0, 0);
        rf_chk("t2_r6", 6, 64'h00000000_22222222);

        // 3: VMOV r7 = r0, even bytes
        preload(7, 64'hFFFFFFFF_FFFFFFFF);
        issue(mk(6'b101010, 7, 0, 0, 3'b011, 2'b00, 6'd5), 0, 0, 0, 0);
        rf_chk("t3_r7", 7, 64'h00FF00FF_00FF00FF);

        // 4: three illegal forms
        issue(mk(6'b000000, 8, 1, 2, 0, 0, 6'd1), 0, 0, 0, 0);
        issue(mk(6'b101010, 8, 1, 2, 0, 0, 6'b010011), 0, 0, 0, 0);
        issue(mk(6'b101010, 8, 1, 2, 3'b101, 0, 6'd1), 0, 0, 0, 0);
        chk("t4_no_wb", wb_valid, 0);
        rf_chk("t4_r8", 8, model[8]);
`ifdef VALU_PERF_CNT_EN
        chk("t4_illegal_cnt", illegal_cnt, 3);
`else
        chk("t4_illegal_cnt", illegal_cnt, 0);
`endif

        // 5: back-to-back dependent adds
        issue(mk(6'b101010, 4, 1, 2, 0, 2'b11, 6'd6), 0, 0, 0, 0);
        acc1 = last_acc;
        issue(mk(6'b101010, 5, 4, 4, 0, 2'b11, 6'd6), 0, 0, 0, 0);
        chk("t5_accept_spacing", last_acc - acc1, ALU_LAT + 1);
        rf_chk("t5_r4", 4, 64'h1D);
        rf_chk("t5_r5", 5, 64'h3A);

        // Same-edge preload of rA: operand must be the pre-write value
        issue(mk(6'b101010, 9, 1, 2, 0, 2'b11, 6'd6), 1, 1, 64'h1234, 0);
        rf_chk("pl_same_edge_r1", 1, 64'h1234);
        // Preload held during WAIT must be ignored
        issue(mk(6'b101010, 10, 1, 2, 3'b100, 2'b01, 6'd3), 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0)
                preload(5'($urandom_range(0, 31)), {$urandom, $urandom});
            if ($urandom_range(0, 4) == 0)
                ins = mk(6'($urandom_range(0, 63)), 5'($urandom), 5'($urandom), 5'($urandom),
                         3'($urandom_range(0, 7)), 2'($urandom), 6'($urandom_range(0, 63)));
            else
                ins = mk(6'b101010, 5'($urandom), 5'($urandom), 5'($urandom),
                         3'($urandom_range(0, 4)), 2'($urandom), 6'($urandom_range(1, 18)));
            issue(ins, 0, 0, 0, 0);
        end
        for (int a = 0; a < 32; a += 5) rf_chk("rand_rf", 5'(a), model[a]);
`ifdef VALU_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, n_ret);
        chk("illegal_cnt", illegal_cnt, n_ill);
`else
        chk("retired_cnt", retired_cnt, 0);
        chk("illegal_cnt", illegal_cnt, 0);
`endif

        // 6: reset one cycle into WAIT aborts the write-back
        @(negedge clk);
        instr = mk(6'b101010, 3, 1, 2, 0, 2'b10, 6'd1); instr_valid = 1;
        @(posedge clk); #1;
        instr_valid = 0;
        chk("t6_in_wait", instr_ready, 0);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("t6_alu_rA", alu_rA, 0);
        chk("t6_alu_rB", alu_rB, 0);
        chk("t6_alu_R_ins", alu_R_ins, 0);
        chk("t6_alu_Op_code", alu_Op_code, 0);
        chk("t6_ready", instr_ready, 1);
        chk("t6_retired", retired_cnt, 0);
        @(negedge clk) rst = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wb_valid) seen++;
        end
        chk("t6_no_wb", seen, 0);
        rf_chk("t6_r3", 3, 0);
        rf_chk("t6_r1", 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/valu_issue.md
Name: valu_issue

Overview:
- Instruction-side front end for the combinational vector ALU (64-bit operands, R_ins/Op_code/WW control, 64-bit result).
- Accepts 32-bit R-type vector instruction words over a valid/ready handshake and decodes them.
- Reads both operands from an internal 32x64 register file and drives registered operands and controls to the ALU.
- Waits a fixed settle time, then writes the ALU result back to rD under the PPP byte-participation mask.

Parameters:
- ALU_LAT, 2, cycles the ALU inputs are held before the result is captured; legal range 1..15.
- NREG, 32, number of 64-bit registers; addresses are 5 bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- instr_valid  in  1  instruction word offered
- instr  in  [0:31]  fields: Op_code[0:5], rD[6:10], rA[11:15], rB[16:20], PPP[21:23], WW[24:25], func[26:31]
- instr_ready  out  1  high only in IDLE
- alu_rA, alu_rB  out  [0:63]  registered operands to the ALU
- alu_R_ins  out  [0:5]  registered func field
- alu_Op_code  out  [0:5]  registered opcode
- alu_WW  out  [0:1]  registered width field
- alu_out  in  [0:63]  ALU result
- wb_valid  out  1  one-cycle pulse after the register-file write
- wb_addr  out  [0:4]  rD of that write
- wb_data  out  [0:63]  merged value written
- illegal  out  1  one-cycle pulse when an illegal instruction is dropped
- rf_we, rf_waddr[0:4], rf_wdata[0:63]  in  preload write port
- rf_raddr[0:4] in, rf_rdata[0:63] out  combinational debug read
- retired_cnt, illegal_cnt  out  [0:31]  performance counters (see optional feature)

Behaviour:
- Reset:
  - State goes to IDLE asynchronously.
  - All alu_* outputs, wb_*, illegal and counters go to 0; instr_ready goes to 1.
  - The register file is cleared to 0.
  - Reset during WAIT aborts the operation; no write-back occurs.
- State IDLE:
  - instr_ready=1. Accept happens on an edge where instr_valid & instr_ready.
  - Legal instruction requires all of: Op_code==6'b101010; func in 6'b000001..6'b010010; PPP in 000..100.
  - Legal accept: latch rf[rA] to alu_rA and rf[rB] to alu_rB, latch func, opcode, WW, rD and PPP; cnt=1; go to WAIT.
  - Illegal accept: illegal=1 for the next cycle; stay in IDLE; no ALU outputs change.
- State WAIT:
  - instr_ready=0 and alu_* held stable.
  - On each edge: if cnt==ALU_LAT, perform the write-back and go to IDLE; otherwise cnt++.
- Timing:
  - An instruction accepted at edge k is written at edge k+ALU_LAT.
  - wb_valid is high in the cycle after edge k+ALU_LAT; instr_ready is high in that same cycle.
  - Peak throughput is one instruction per ALU_LAT+1 cycles.
- PPP merge, new = alu_out byte where enabled, else old rf[rD] byte (byte 0 = bits[0:7]):
  - 000 enables all bytes.
  - 001 enables bytes 0-3.
  - 010 enables bytes 4-7.
  - 011 enables bytes 0, 2, 4, 6.
  - 100 enables bytes 1, 3, 5, 7.
- Hazards: only one instruction is in flight, so RAW hazards resolve naturally; operand reads at accept see every earlier write.
- Preload port:
  - rf_we is honoured only in IDLE and ignored otherwise.
  - If rf_we and an accept fall on the same edge, operand reads return the pre-write value.
- instr_valid may drop without accepting; nothing is latched.
- The ALU is combinational and its result is not re-registered before the merge.

Optional Feature:
- Macro: VALU_PERF_CNT_EN.
- Defined:
  - retired_cnt increments on each write-back.
  - illegal_cnt increments on each illegal pulse.
  - Both counters wrap at 2^32 and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package valu_pkg:
  - OPC_VALU=6'b101010.
  - Func constants VAND=000001 through VSQRT=010010.
  - PPP codes, WW codes.
  - Instruction field bit-slice constants.
  - State enum {IDLE, WAIT}.
- Sub-module valu_regfile:
  - NREG x 64 storage with async clear.
  - Two read ports for operands, one debug read port, one write port.
  - The issue FSM arbitrates the single write port between preload and write-back.

Test Plan:
1. Preload r1=64'h0F, r2=64'h0E. Issue 32'hA8611081 (VAND rD=3 rA=1 rB=2 PPP=000 WW=10); ALU_LAT=2. Expect instr_ready low for 2 cycles, alu_R_ins=000001, wb_valid pulse with wb_addr=3, rf[3]=64'h0E.
2. Preload r6=64'h11111111_22222222. Issue VADD rD=6 rA=1 rB=2 PPP=001 WW=11. Expect rf[6]=64'h00000000_22222222 (upper write of 64'h1D's upper half, lower kept).
3. Preload r7=64'hFFFFFFFF_FFFFFFFF. Issue VMOV rD=7 rA=0 PPP=011 with r0=0. Expect rf[7]=64'h00FF00FF_00FF00FF.
4. Issue Op_code=000000, or func=6'b010011, or PPP=101. Expect an illegal pulse each time, instr_ready continuously 1, no wb_valid, register file unchanged; with VALU_PERF_CNT_EN, illegal_cnt=3.
5. Back-to-back: VADD r4=r1+r2 WW=11, then VADD r5=r4+r4 issued the cycle instr_ready returns. Expect rf[4]=64'h1D, rf[5]=64'h3A; second accept occurs ALU_LAT+1 cycles after the first.
6. Assert rst one cycle into WAIT of VAND rD=3. Expect alu_* =0, instr_ready=1, wb_valid never pulses, rf[3]=0.
